// File: rtl/branch_predecode_ras_pkg.sv
// Shared MIPS control-flow decode constants, the per-lane class struct,
// and the return-address-stack pointer type.
package branch_predecode_ras_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_COP1    = 6'b010001;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam int RAS_DEPTH_DFLT = 8;

  typedef logic [$clog2(RAS_DEPTH_DFLT)-1:0] ras_ptr_t;

  typedef struct packed {
    logic branch;
    logic jump_i;
    logic jump_r;
    logic call;
    logic ret;
  } cf_class_t;

endpackage

// File: rtl/branch_lane_classify.sv
// Combinational classifier for one fetch lane: control-flow class plus the
// static (PC-relative or region) target where one exists.
module branch_lane_classify
  import branch_predecode_ras_pkg::*;
#(
  parameter int ENABLE_FPU = 0
) (
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output cf_class_t   cls_o,
  output logic [31:0] target_o
);

  logic [5:0]  opcode_s;
  logic [4:0]  rs_s;
  logic [4:0]  rd_s;
  logic        jump_r_s;
  logic        jump_i_s;
  logic        branch_s;
  logic        fpu_br_s;
  logic [31:0] pc4_s;
  logic [31:0] bimm_s;

  assign opcode_s = instr_i[31:26];
  assign rs_s     = instr_i[25:21];
  assign rd_s     = instr_i[15:11];

  assign jump_r_s = (opcode_s == OP_SPECIAL) && (instr_i[5:1] == FN_JR[5:1]);
  assign jump_i_s = (opcode_s[5:1] == OP_JAL[5:1]);
  assign fpu_br_s = (ENABLE_FPU != 0) && (opcode_s == OP_COP1) &&
                    (rs_s == 5'b01000) && !instr_i[17];
  assign branch_s = (opcode_s[5:2] == 4'b0001) ||
                    ((opcode_s == OP_REGIMM) && (instr_i[19:17] == 3'b000)) ||
                    fpu_br_s;

  assign cls_o.branch = branch_s;
  assign cls_o.jump_i = jump_i_s;
  assign cls_o.jump_r = jump_r_s;
  // JALR link to $31, JAL, or the REGIMM and-link branches
  assign cls_o.call   = (jump_r_s && (instr_i[5:0] == FN_JALR) && (rd_s == 5'd31)) ||
                        (opcode_s == OP_JAL) ||
                        ((opcode_s == OP_REGIMM) && (instr_i[20:17] == 4'b1000));
  assign cls_o.ret    = jump_r_s && (rs_s == 5'd31);

  assign pc4_s  = pc_i + 32'd4;
  assign bimm_s = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

  // Static target; register jumps resolve elsewhere (RAS or not at all)
  always_comb begin
    target_o = 32'd0;
    if (branch_s) begin
      target_o = pc4_s + bimm_s;
    end else if (jump_i_s) begin
      target_o = {pc4_s[31:28], instr_i[25:0], 2'b00};
    end else begin
      target_o = 32'd0;
    end
  end

endmodule

// File: rtl/branch_predecode_ras.sv
// Fetch-group predecode stage: finds the first control-flow lane, predicts
// its target (returns via a circular RAS) and registers the group.
module branch_predecode_ras
  import branch_predecode_ras_pkg::*;
#(
  parameter  int FETCH_WIDTH = 2,
  parameter  int RAS_DEPTH   = RAS_DEPTH_DFLT,
  parameter  int ENABLE_FPU  = 0,
  localparam int LW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [32*FETCH_WIDTH-1:0] in_instr,
  input  logic [FETCH_WIDTH-1:0]   in_lane_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [32*FETCH_WIDTH-1:0] out_instr,
  output logic [FETCH_WIDTH-1:0]   out_lane_valid,
  output logic                     out_cf_found,
  output logic [LW-1:0]            out_cf_lane,
  output logic                     out_is_branch,
  output logic                     out_is_jump_i,
  output logic                     out_is_jump_r,
  output logic                     out_is_call,
  output logic                     out_is_return,
  output logic [31:0]              out_target,
  output logic                     out_target_valid,
  output logic                     out_need_delay_slot,
  output logic [CW-1:0]            ras_count
);

  cf_class_t                cls_s [FETCH_WIDTH];
  logic [31:0]              tgt_s [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0]   hit_s;
  logic                     cf_found_s;
  logic [LW-1:0]            cf_lane_s;
  cf_class_t                cf_cls_s;
  logic [FETCH_WIDTH-1:0]   lane_mask_s;
  logic                     next_valid_s;
  logic                     need_ds_s;
  logic [31:0]              sel_pc8_s;
  logic [31:0]              target_s;
  logic                     target_valid_s;
  logic                     accept_s;
  logic                     push_s;
  logic                     pop_s;

  logic [31:0]              ras_q [RAS_DEPTH];
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     ras_we_s;
  logic [PW-1:0]            ras_widx_s;
  logic [31:0]              ras_top_s;

  logic                     out_valid_q;
  logic [31:0]              out_pc_q;
  logic [32*FETCH_WIDTH-1:0] out_instr_q;
  logic [FETCH_WIDTH-1:0]   out_lane_valid_q;
  logic                     cf_found_q;
  logic [LW-1:0]            cf_lane_q;
  cf_class_t                cf_cls_q;
  logic [31:0]              target_q;
  logic                     target_valid_q;
  logic                     need_ds_q;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    branch_lane_classify #(.ENABLE_FPU(ENABLE_FPU)) u_classify (
      .instr_i  (in_instr[32*g +: 32]),
      .pc_i     (in_pc + 32'(4 * g)),
      .cls_o    (cls_s[g]),
      .target_o (tgt_s[g])
    );
    assign hit_s[g] = in_lane_valid[g] &&
                      (cls_s[g].branch || cls_s[g].jump_i || cls_s[g].jump_r);
  end

  assign in_ready  = !flush && (!out_valid_q || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign ras_top_s = ras_q[ptr_q - PW'(1)];

  // Priority encode the first cf lane, then derive lane mask and target
  always_comb begin
    cf_lane_s = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      cf_lane_s = hit_s[i] ? LW'(i) : cf_lane_s;
    end
    cf_found_s   = |hit_s;
    cf_cls_s     = cf_found_s ? cls_s[cf_lane_s] : '0;
    next_valid_s = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_mask_s[i] = in_lane_valid[i] &&
                       (!cf_found_s || (i <= int'(cf_lane_s) + 1));
      next_valid_s   = (i == int'(cf_lane_s) + 1) ? in_lane_valid[i] : next_valid_s;
    end
    need_ds_s = cf_found_s && !next_valid_s;
    sel_pc8_s = in_pc + (32'(cf_lane_s) << 2) + 32'd8;
    if (cf_cls_s.ret) begin
      target_s       = ras_top_s;
      target_valid_s = (count_q != '0);
    end else if (cf_cls_s.branch || cf_cls_s.jump_i) begin
      target_s       = tgt_s[cf_lane_s];
      target_valid_s = 1'b1;
    end else begin
      target_s       = 32'd0;
      target_valid_s = 1'b0;
    end
  end

  assign push_s = accept_s && cf_cls_s.call;
  assign pop_s  = accept_s && cf_cls_s.ret;

  // RAS next state: combined call+return rewrites the top in place
  always_comb begin
    ptr_d      = ptr_q;
    count_d    = count_q;
    ras_we_s   = 1'b0;
    ras_widx_s = ptr_q;
    if (push_s && pop_s) begin
      ras_we_s   = 1'b1;
      ras_widx_s = ptr_q - PW'(1);
      count_d    = (count_q == '0) ? CW'(1) : count_q;
    end else if (push_s) begin
      ras_we_s = 1'b1;
      ptr_d    = ptr_q + PW'(1);
      count_d  = (count_q == CW'(RAS_DEPTH)) ? count_q : count_q + CW'(1);
    end else if (pop_s && (count_q != '0)) begin
      ptr_d   = ptr_q - PW'(1);
      count_d = count_q - CW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // RAS storage, pointer and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= 32'd0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (ras_we_s) ras_q[ras_widx_s] <= sel_pc8_s;
    end
  end

  // Output pipeline register with valid/ready handshake; flush has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_pc_q         <= 32'd0;
      out_instr_q      <= '0;
      out_lane_valid_q <= '0;
      cf_found_q       <= 1'b0;
      cf_lane_q        <= '0;
      cf_cls_q         <= '0;
      target_q         <= 32'd0;
      target_valid_q   <= 1'b0;
      need_ds_q        <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept_s) begin
      out_valid_q      <= 1'b1;
      out_pc_q         <= in_pc;
      out_instr_q      <= in_instr;
      out_lane_valid_q <= lane_mask_s;
      cf_found_q       <= cf_found_s;
      cf_lane_q        <= cf_lane_s;
      cf_cls_q         <= cf_cls_s;
      target_q         <= target_s;
      target_valid_q   <= target_valid_s;
      need_ds_q        <= need_ds_s;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  assign out_valid           = out_valid_q;
  assign out_pc              = out_pc_q;
  assign out_instr           = out_instr_q;
  assign out_lane_valid      = out_lane_valid_q;
  assign out_cf_found        = cf_found_q;
  assign out_cf_lane         = cf_lane_q;
  assign out_is_branch       = cf_cls_q.branch;
  assign out_is_jump_i       = cf_cls_q.jump_i;
  assign out_is_jump_r       = cf_cls_q.jump_r;
  assign out_is_call         = cf_cls_q.call;
  assign out_is_return       = cf_cls_q.ret;
  assign out_target          = target_q;
  assign out_target_valid    = target_valid_q;
  assign out_need_delay_slot = need_ds_q;
  assign ras_count           = count_q;

endmodule

// File: tb/tb_branch_predecode_ras.sv
// Directed bench for branch_predecode_ras (2-wide, 8-entry RAS, no FPU).
module tb_branch_predecode_ras;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] JAL0 = 32'h0C10_0040;
  localparam logic [31:0] JR31 = 32'h03E0_0008;
  localparam logic [31:0] BEQM = 32'h1000_FFFF;
  localparam logic [31:0] JALR = 32'h03E0_F809;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = 32'd0;
  logic [63:0] in_instr = 64'd0;
  logic [1:0]  in_lane_valid = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [63:0] out_instr;
  logic [1:0]  out_lane_valid;
  logic        out_cf_found;
  logic [0:0]  out_cf_lane;
  logic        out_is_branch, out_is_jump_i, out_is_jump_r, out_is_call, out_is_return;
  logic [31:0] out_target;
  logic        out_target_valid;
  logic        out_need_delay_slot;
  logic [3:0]  ras_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predecode_ras #(.FETCH_WIDTH(2), .RAS_DEPTH(8), .ENABLE_FPU(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_lane_valid(in_lane_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_lane_valid(out_lane_valid), .out_cf_found(out_cf_found), .out_cf_lane(out_cf_lane),
    .out_is_branch(out_is_branch), .out_is_jump_i(out_is_jump_i), .out_is_jump_r(out_is_jump_r),
    .out_is_call(out_is_call), .out_is_return(out_is_return), .out_target(out_target),
    .out_target_valid(out_target_valid), .out_need_delay_slot(out_need_delay_slot),
    .ras_count(ras_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] lv);
    in_pc = pc; in_instr = {i1, i0}; in_lane_valid = lv;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ras_count", 32'(ras_count), 32'd0);
    check("rst_target", out_target, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // JAL in lane 1
    send(32'h8000_1000, NOP, JAL0, 2'b11);
    check("jal_valid", 32'(out_valid), 32'd1);
    check("jal_pc", out_pc, 32'h8000_1000);
    check("jal_instr_hi", out_instr[63:32], JAL0);
    check("jal_lane", 32'(out_cf_lane), 32'd1);
    check("jal_call", 32'(out_is_call), 32'd1);
    check("jal_jump_i", 32'(out_is_jump_i), 32'd1);
    check("jal_target", out_target, 32'h8040_0100);
    check("jal_tv", 32'(out_target_valid), 32'd1);
    check("jal_ds", 32'(out_need_delay_slot), 32'd1);
    check("jal_count", 32'(ras_count), 32'd1);

    // JR $31 returns to the pushed link address
    send(32'h8000_2000, JR31, NOP, 2'b11);
    check("ret_is_return", 32'(out_is_return), 32'd1);
    check("ret_jump_r", 32'(out_is_jump_r), 32'd1);
    check("ret_lane", 32'(out_cf_lane), 32'd0);
    check("ret_target", out_target, 32'h8000_100C);
    check("ret_tv", 32'(out_target_valid), 32'd1);
    check("ret_count", 32'(ras_count), 32'd0);
    check("ret_lanes", 32'(out_lane_valid), 32'd3);
    check("ret_ds", 32'(out_need_delay_slot), 32'd0);

    // BEQ with offset -1 word
    send(32'h0000_0000, BEQM, NOP, 2'b11);
    check("beq0_branch", 32'(out_is_branch), 32'd1);
    check("beq0_target", out_target, 32'h0000_0000);
    check("beq0_lanes", 32'(out_lane_valid), 32'd3);
    check("beq0_ds", 32'(out_need_delay_slot), 32'd0);
    send(32'h0000_0000, NOP, BEQM, 2'b11);
    check("beq1_target", out_target, 32'h0000_0004);
    check("beq1_ds", 32'(out_need_delay_slot), 32'd1);

    // Branch in an invalid lane is ignored; empty group passes through
    send(32'h0000_0100, BEQM, NOP, 2'b10);
    check("nocf_found", 32'(out_cf_found), 32'd0);
    check("nocf_target", out_target, 32'd0);
    check("nocf_lanes", 32'(out_lane_valid), 32'd2);
    send(32'h0000_0200, BEQM, BEQM, 2'b00);
    check("novalid_valid", 32'(out_valid), 32'd1);
    check("novalid_found", 32'(out_cf_found), 32'd0);

    // Return on an empty stack
    send(32'h0000_0300, JR31, NOP, 2'b01);
    check("emptypop_tv", 32'(out_target_valid), 32'd0);
    check("emptypop_count", 32'(ras_count), 32'd0);

    // Nine calls into an 8-deep stack, then nine returns
    for (int k = 0; k < 9; k++) send(32'h0000_1000 + 32'(k * 256), 32'h0C00_0000, NOP, 2'b01);
    check("full_count", 32'(ras_count), 32'd8);
    for (int r = 0; r < 8; r++) begin
      send(32'h0000_2000, JR31, NOP, 2'b01);
      check($sformatf("pop%0d_target", r), out_target, 32'h0000_1008 + 32'((8 - r) * 256));
      check($sformatf("pop%0d_tv", r), 32'(out_target_valid), 32'd1);
    end
    check("drain_count", 32'(ras_count), 32'd0);
    send(32'h0000_2000, JR31, NOP, 2'b01);
    check("pop8_tv", 32'(out_target_valid), 32'd0);

    // JALR $31,$31 on empty stack, then a return that uses its link
    send(32'h0000_3000, JALR, NOP, 2'b01);
    check("jalr_call", 32'(out_is_call), 32'd1);
    check("jalr_ret", 32'(out_is_return), 32'd1);
    check("jalr_tv", 32'(out_target_valid), 32'd0);
    check("jalr_count", 32'(ras_count), 32'd1);
    send(32'h0000_3100, JR31, NOP, 2'b01);
    check("jalr_pop_target", out_target, 32'h0000_3008);
    check("jalr_pop_count", 32'(ras_count), 32'd0);

    // Back-pressure for three cycles, then flush
    send(32'h0000_0040, BEQM, NOP, 2'b01);
    in_pc = 32'h0000_5000; in_instr = {NOP, JAL0}; in_lane_valid = 2'b01;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("stall%0d_target", c), out_target, 32'h0000_0040);
      check($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_count", c), 32'(ras_count), 32'd0);
    end
    flush = 1'b1; out_ready = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_count", 32'(ras_count), 32'd0);
    flush = 1'b0; in_valid = 1'b0;

    // Asynchronous reset in the middle of a stall
    for (int k = 0; k < 5; k++) send(32'h0000_6000 + 32'(k * 16), JAL0, NOP, 2'b01);
    check("pre_rst_count", 32'(ras_count), 32'd5);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #3;
    check("stall_hold_count", 32'(ras_count), 32'd5);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(ras_count), 32'd0);
    check("arst_target", out_target, 32'd0);
    check("arst_call", 32'(out_is_call), 32'd0);
    check("arst_pc", out_pc, 32'd0);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predecode_ras.md
# branch_predecode_ras

Fetch-group branch predecoder for the MIPS front end. Decodes `FETCH_WIDTH` instructions per cycle, locates the first control-flow instruction, and computes its static target. Predicts return targets from a circular return-address stack (RAS). Sits as one registered pipeline stage between the instruction-fetch response and the instruction queue.

## Interface
- `FETCH_WIDTH`, default 2: instructions per fetch group, ≥1.
- `RAS_DEPTH`, default 8: RAS entries, power of two, ≥2.
- `ENABLE_FPU`, default 0: when 1, BC1F/BC1T (opcode 010001, rs 01000, bit 17 = 0) count as conditional branches.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: discard the registered group and block acceptance this cycle.
- `in_valid` in 1: fetch group valid.
- `in_ready` out 1: stage can accept.
- `in_pc` in 32: word-aligned address of lane 0; lane i is at `in_pc + 4*i`.
- `in_instr` in 32*FETCH_WIDTH: lane i occupies bits [32i+31:32i].
- `in_lane_valid` in FETCH_WIDTH: per-lane valid.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_pc`, `out_instr` out 32 / 32*FETCH_WIDTH: registered copies of the inputs.
- `out_lane_valid` out FETCH_WIDTH: lane mask after delay-slot truncation.
- `out_cf_found` out 1: a control-flow lane exists.
- `out_cf_lane` out $clog2(FETCH_WIDTH) (min 1): index of that lane.
- `out_is_branch`, `out_is_jump_i`, `out_is_jump_r`, `out_is_call`, `out_is_return` out 1 each: class of the cf lane.
- `out_target` out 32: predicted target.
- `out_target_valid` out 1: target is meaningful.
- `out_need_delay_slot` out 1: cf lane is the last valid lane, so its delay slot is in the next group.
- `ras_count` out $clog2(RAS_DEPTH)+1: current RAS occupancy.

## Operation
- Per-lane classification:
  - jump_r: opcode 0, funct[5:1] = 00100.
  - jump_i: opcode[5:1] = 00001.
  - branch: opcode[5:2] = 0001, or REGIMM with rt[19:17] = 0, plus the FPU case when enabled.
  - call: JALR with rd = 31, JAL, or REGIMM rt[20:17] = 1000.
  - return: JR $31, or JALR with rs = 31.
- cf lane = lowest-index valid lane that is branch, jump_i or jump_r. Only this lane affects targets and the RAS.
- Target, with `p` = lane PC (all arithmetic 32-bit, wrapping mod 2^32):
  - branch: `p + 4 + sext(imm16<<2)`, target_valid = 1 (taken-path target).
  - jump_i: `{(p+4)[31:28], imm26, 2'b00}`, target_valid = 1.
  - return: RAS top; target_valid = 1 only if `ras_count` > 0 before the pop.
  - other jump_r: target 0, target_valid = 0.
- Lane mask: lanes with index > cf_lane+1 are cleared in `out_lane_valid`. `out_need_delay_slot` = 1 when no valid lane exists at cf_lane+1.
- RAS updates only on an accepted group (`in_valid && in_ready && !flush`):
  - call: push `p + 8`.
  - return: pop.
  - both (JALR $31,$31): target = old top, then top is replaced with `p + 8`; count unchanged, or becomes 1 if it was 0.
- RAS full push: the oldest entry is overwritten; count saturates at RAS_DEPTH.
- RAS empty pop: count stays 0 and no pointer change.
- No cf lane: all class flags 0, target 0, target_valid 0, `out_lane_valid` = input mask.
- No valid lanes: same as no cf lane; the group still passes through.

## Timing
- Latency: 1 cycle from acceptance to `out_valid`.
- `in_ready = !flush && (!out_valid || out_ready)`. This gives full throughput, with no skid buffer.
- Output register loads on acceptance. `out_valid` clears on `out_ready` without a new acceptance.
- Outputs and `out_valid` stay stable while `out_valid && !out_ready`.
- `flush` is 1: `out_valid` is 0 next cycle, nothing is accepted, and the RAS is untouched. Flush wins over a simultaneous `out_ready` or `in_valid`.
- The RAS top read for a return reflects all previously accepted groups, with no forwarding hazard. This holds because updates commit at the same edge that loads the output register.
- Reset (asynchronous assert, at any time including mid-stall):
  - `out_valid` = 0; all `out_*` data and flags = 0.
  - `ras_count` = 0, RAS pointer = 0, entries = 0.
  - `in_ready` = 1 once `rst_n` = 1.

## Structure
- Shared package holds:
  - the opcode/funct constants (SPECIAL, REGIMM, COP1, JR/JALR funct);
  - the cf-class struct (branch, jump_i, jump_r, call, return);
  - `ras_ptr_t` sized from RAS_DEPTH.
- One sub-module, `branch_lane_classify`: combinational, one instruction plus PC in, class struct plus target out. Instantiated FETCH_WIDTH times via generate.
- Priority encoder, RAS and output register live in the top module.

## Test plan
- JAL 0x0C100040 at lane 1, `in_pc` = 0x80001000 → cf_lane = 1, is_call = 1, target 0x80400100, `ras_count` 0→1, RAS top = 0x8000100C.
- Follow-up group with JR $31 (0x03E00008) at lane 0, `in_pc` = 0x80002000 → is_return = 1, target 0x8000100C, target_valid = 1, `ras_count` 1→0.
- BEQ with imm 0xFFFF at `in_pc` = 0x0 lane 0 → target 0x00000000, and lane 1 kept. The same instruction in lane 1 of a 2-wide group → `out_need_delay_slot` = 1.
- Nine calls with RAS_DEPTH = 8, then nine returns → the first eight returns predict newest→second-oldest, `ras_count` holds at 8, and the ninth return has target_valid = 0.
- `out_ready` = 0 for 3 cycles with `in_valid` = 1 → outputs frozen, `in_ready` = 0, no RAS change. `flush` in cycle 2 → `out_valid` = 0 next cycle, and the RAS is unchanged.
- `rst_n` pulsed low mid-stall with `ras_count` = 5 → all outputs 0 and `ras_count` = 0 immediately, with no clock edge needed.
